// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM states and op encodings.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// Combinational 1-bit add/subtract cell; cnext is carry (add) or borrow (sub).
import serial_addsub_pkg::*;

module addsub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic op,
    output logic s,
    output logic cnext
);

    always_comb begin
        s = x ^ y ^ cin;
        if (op == OP_SUB) begin
            // Borrow out when x - y - cin goes negative.
            cnext = (~x & y) | (~(x ^ y) & cin);
        end else begin
            cnext = (x & y) | ((x ^ y) & cin);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial W-bit adder/subtractor, LSB first, one shared cell, done pulse on completion.
// Optional two's-complement overflow output enabled with SERIAL_ADDSUB_OVF_EN.
import serial_addsub_pkg::*;

module serial_addsub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_sr_q, a_sr_d;
    logic [W-1:0]   b_sr_q, b_sr_d;
    logic [W-1:0]   res_sr_q, res_sr_d;
    logic [W-1:0]   result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           op_q, op_d;
    logic           carry_q, carry_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cout_q, cout_d;
    logic           cell_s, cell_c;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    addsub_bit_cell u_cell (
        .x     (a_sr_q[0]),
        .y     (b_sr_q[0]),
        .cin   (carry_q),
        .op    (op_q),
        .s     (cell_s),
        .cnext (cell_c)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    op_d    = op;
                    carry_d = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
                    a_msb_d = a[W-1];
                    b_msb_d = b[W-1];
`endif
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = {cell_s, res_sr_q[W-1:1]};
                carry_d  = cell_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Final bit lands straight in the output register, not via res_sr_q.
                    result_d = {cell_s, res_sr_q[W-1:1]};
                    cout_d   = cell_c;
`ifdef SERIAL_ADDSUB_OVF_EN
                    if (op_q == OP_SUB) begin
                        ovf_d = (a_msb_q != b_msb_q) && (cell_s != a_msb_q);
                    end else begin
                        ovf_d = (a_msb_q == b_msb_q) && (cell_s != a_msb_q);
                    end
`endif
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed vector bench for serial_addsub (W=8); ovf checked when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_addsub #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
        logic         exp_c;
        logic         exp_v;
    } vec_t;

    vec_t vecs[11];

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic read_ovf();
`ifdef SERIAL_ADDSUB_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic launch(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        op    = opv;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operands wander during RUN; the DUT must ignore them.
        a  = W'($urandom_range(0, 255));
        b  = W'($urandom_range(0, 255));
        op = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] r, output logic c, output logic v,
                          output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        launch(opv, av, bv);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                r   = result;
                c   = cout;
                v   = read_ovf();
                break;
            end
        end
        @(negedge clk);
        check("done_pulse_width", {31'd0, done}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           lat;
        int           bcnt;
        int           dcnt;
        int           first_done;
        logic         busy_ok;
        logic         hold_ok;

        vecs[0]  = '{1'b0, 8'h3C, 8'h29, 8'h65, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'hC8, 8'hC8, 8'h90, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_cout",   {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors: value, latency and busy length for each.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, c, v, lat, bcnt);
            check($sformatf("v%0d_result", i), {24'd0, r}, {24'd0, vecs[i].exp_r});
            check($sformatf("v%0d_cout", i), {31'd0, c}, {31'd0, vecs[i].exp_c});
            check($sformatf("v%0d_latency", i), lat, W + 1);
            check($sformatf("v%0d_busy_cycles", i), bcnt, W);
`ifdef SERIAL_ADDSUB_OVF_EN
            check($sformatf("v%0d_ovf", i), {31'd0, v}, {31'd0, vecs[i].exp_v});
`endif
        end

        // start pulsed mid-RUN must be ignored.
        launch(1'b0, 8'h10, 8'h20);
        dcnt = 0;
        first_done = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
                op    = 1'b1;
            end else if (k == 4) begin
                start = 1'b0;
            end
            if (busy !== (k <= W)) busy_ok = 1'b0;
            if (done) begin
                dcnt++;
                if (first_done == 0) begin
                    first_done = k;
                    r = result;
                end
            end
        end
        check("ign_done_count", dcnt, 1);
        check("ign_latency", first_done, W + 1);
        check("ign_result", {24'd0, r}, 32'h30);
        check("ign_busy_shape", {31'd0, busy_ok}, 32'd1);

        // Back-to-back: relaunch in the DONE cycle of the first operation.
        launch(1'b0, 8'h11, 8'h22);
        first_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                first_done = k;
                break;
            end
        end
        check("b2b_first_latency", first_done, W + 1);
        check("b2b_first_result", {24'd0, result}, 32'h33);
        op    = 1'b1;
        a     = 8'h09;
        b     = 8'h04;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        hold_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (result !== 8'h33) hold_ok = 1'b0;
        end
        check("b2b_spacing", lat, W + 1);
        check("b2b_hold_first", {31'd0, hold_ok}, 32'd1);
        check("b2b_result", {24'd0, result}, 32'h05);
        check("b2b_cout", {31'd0, cout}, 32'd0);

        // Mid-RUN asynchronous reset after edge 3 of RUN.
        launch(1'b0, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy",   {31'd0, busy}, 32'd0);
        check("mrst_done",   {31'd0, done}, 32'd0);
        check("mrst_result", {24'd0, result}, 32'd0);
        check("mrst_cout",   {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'h01, 8'h01, r, c, v, lat, bcnt);
        check("mrst_after_result", {24'd0, r}, 32'h02);
        check("mrst_after_cout", {31'd0, c}, 32'd0);
        check("mrst_after_latency", lat, W + 1);
        check("mrst_after_busy", bcnt, W);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
